// File: rtl/mic_pkg.sv
// mic_pkg: shared types, widths and the saturation helper for the microphone
// sample conditioning path (mic_sample_cond and its output FIFO).
package mic_pkg;

  // Conditioning FSM: one state per pipeline step of a single input sample.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DC   = 2'd1,
    S_ACC  = 2'd2,
    S_PUSH = 2'd3
  } mic_state_e;

  localparam int MIC_IN_W  = 24;
  localparam int MIC_OUT_W = 16;

  // Working width of the scaled value before it is clamped to the output width.
  localparam int SAT_W = 64;
  localparam logic signed [SAT_W-1:0] SAT_ONE = 64'sd1;

  // Clamp a signed value to the two's complement range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_ONE <<< (width - 1)) - SAT_ONE;
    min_v = -(SAT_ONE <<< (width - 1));
    if (value > max_v) begin
      saturate = max_v;
    end else if (value < min_v) begin
      saturate = min_v;
    end else begin
      saturate = value;
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with occupancy count.
// A push while full is dropped unless a pop happens in the same cycle;
// the caller decides how to report a dropped push using 'full'.
module sample_fifo
  import mic_pkg::*;
#(
  parameter int  WIDTH = MIC_OUT_W,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push_s, do_pop_s;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  // Head of queue is visible without a read request; zero when nothing is queued.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Decide which of push/pop take effect and compute the next pointers and count.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mic_sample_cond.sv
// mic_sample_cond: conditions raw I2S microphone samples. Each strobed sample
// has its DC offset removed, DECIM samples are block-averaged, the average is
// scaled to OUT_W bits with saturation and queued in a FWFT output FIFO.
// Build option MIC_COND_DC_EN: when defined the DC tracker is active; when
// undefined the DC step passes samples through unchanged (same timing).
module mic_sample_cond
  import mic_pkg::*;
#(
  parameter int  IN_W       = MIC_IN_W,
  parameter int  OUT_W      = MIC_OUT_W,
  parameter int  DECIM      = 4,
  parameter int  DC_SHIFT   = 8,
  parameter int  GAIN_SHIFT = 0,
  parameter int  FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [IN_W-1:0]  in_sample,
  input  logic             in_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int DEC_SH  = $clog2(DECIM);
  localparam int CNT_W   = DEC_SH + 1;
  localparam int Y_W     = IN_W + 1;
  localparam int SUM_W   = IN_W + DEC_SH + 1;
  localparam int DC_W    = IN_W + DC_SHIFT;
  localparam int NORM_SH = IN_W - OUT_W;

  mic_state_e              state_q, state_d;
  logic signed [IN_W-1:0]  x_q, x_d;
  logic signed [Y_W-1:0]   y_q, y_d;
  logic signed [Y_W-1:0]   y_calc_s;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic signed [DC_W-1:0]  dc_acc_s;
  logic signed [IN_W-1:0]  dc_est_s;
  logic signed [SUM_W-1:0] avg_s;
  logic signed [SAT_W-1:0] scaled_s;
  logic [OUT_W-1:0]        push_val_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    busy_drop_s;
  logic                    fifo_drop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;

`ifdef MIC_COND_DC_EN
  logic signed [DC_W-1:0] dc_acc_q, dc_acc_d;

  // Move the DC estimate by y each time a sample passes through S_DC.
  always_comb begin
    if (enable && (state_q == S_DC)) begin
      dc_acc_d = dc_acc_q + DC_W'(y_calc_s);
    end else begin
      dc_acc_d = dc_acc_q;
    end
  end

  // DC accumulator; survives enable=0 so the estimate is not relearned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc_acc_q <= '0;
    end else begin
      dc_acc_q <= dc_acc_d;
    end
  end

  assign dc_acc_s = dc_acc_q;
`else
  // No tracker: the estimate is a constant zero, so y equals x.
  assign dc_acc_s = '0;
`endif

  // DC-corrected sample and the scaled block average.
  assign dc_est_s   = IN_W'(dc_acc_s >>> DC_SHIFT);
  assign y_calc_s   = Y_W'(x_q) - Y_W'(dc_est_s);
  assign avg_s      = sum_q >>> DEC_SH;
  assign scaled_s   = (SAT_W'(avg_s) <<< GAIN_SHIFT) >>> NORM_SH;
  assign push_val_s = OUT_W'(saturate(scaled_s, OUT_W));

  // FSM next state and datapath: one step per cycle; enable=0 abandons work.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    push_s      = 1'b0;
    busy_drop_s = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      sum_d   = '0;
      cnt_d   = '0;
    end else begin
      if (in_rdy && (state_q != S_IDLE)) begin
        busy_drop_s = 1'b1;
      end else begin
        busy_drop_s = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (in_rdy) begin
            x_d     = in_sample;
            state_d = S_DC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DC: begin
          y_d     = y_calc_s;
          state_d = S_ACC;
        end
        S_ACC: begin
          sum_d = sum_q + SUM_W'(y_q);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(DECIM)) begin
            state_d = S_PUSH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PUSH: begin
          push_s  = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // A push into a full FIFO is lost only when no pop frees a slot that cycle.
  assign pop_s       = out_ready;
  assign fifo_drop_s = push_s & fifo_full_s & ~(out_ready & ~fifo_empty_s);

  // Sticky overflow: a new error wins over a same-cycle clear.
  always_comb begin
    if (busy_drop_s || fifo_drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow  = ovf_q;
  assign out_valid = ~fifo_empty_s;

  sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_val_s),
    .rdata (out_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_mic_sample_cond.sv
// tb_mic_sample_cond: directed bench for mic_sample_cond. Two instances run
// side by side (GAIN_SHIFT 0 and 2). A transaction-level model predicts the
// queued output words, occupancy and overflow flag; hand-computed literals
// pin the model. MIC_COND_DC_EN selects the DC-tracker expectations.
module tb_mic_sample_cond;

  localparam int DECIM = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] in_sample;
  logic        in_rdy;
  logic        out_ready;
  logic        clr_ovf;
  logic [15:0] out_data, out_data_g2;
  logic        out_valid, out_valid_g2;
  logic [4:0]  fifo_level, fifo_level_g2;
  logic        overflow, overflow_g2;

  always #5 clk = ~clk;

  mic_sample_cond #(.GAIN_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_sample(in_sample), .in_rdy(in_rdy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf));

  mic_sample_cond #(.GAIN_SHIFT(2)) dut_g2 (
    .clk(clk), .rst(rst), .enable(enable), .in_sample(in_sample), .in_rdy(in_rdy),
    .out_data(out_data_g2), .out_valid(out_valid_g2), .out_ready(out_ready),
    .fifo_level(fifo_level_g2), .overflow(overflow_g2), .clr_ovf(clr_ovf));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint      m_dc, m_sum;
  int          m_n, cyc, free_cyc;
  int          due_cyc[$];
  logic [15:0] due_v0[$], due_v2[$];
  logic [15:0] q0[$], q2[$];
  bit          m_ovf;

  // Output word for a block sum: average, gain, drop 8 LSBs, clamp to 16 bits.
  function automatic logic [15:0] model_out(input longint s, input int g);
    longint v;
    v = ((s >>> $clog2(DECIM)) <<< g) >>> 8;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  // Per-cycle transaction model: sample acceptance, pending pushes, FIFO, flag.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_dc = 0; m_sum = 0; m_n = 0; cyc = 0; free_cyc = 0; m_ovf = 0;
      due_cyc.delete(); due_v0.delete(); due_v2.delete(); q0.delete(); q2.delete();
    end else begin
      bit pop, full, set;
      longint x, y;
      set  = 0;
      pop  = (q0.size() != 0) && out_ready;
      full = (q0.size() == DEPTH);
      if (!enable) begin
        m_sum = 0; m_n = 0; free_cyc = cyc + 1;
        due_cyc.delete(); due_v0.delete(); due_v2.delete();
      end
      if (pop) begin
        void'(q0.pop_front()); void'(q2.pop_front());
      end
      if (due_cyc.size() != 0 && due_cyc[0] == cyc) begin
        if (!full || pop) begin
          q0.push_back(due_v0[0]); q2.push_back(due_v2[0]);
        end else begin
          set = 1;
        end
        void'(due_cyc.pop_front()); void'(due_v0.pop_front()); void'(due_v2.pop_front());
      end
      if (enable && in_rdy) begin
        if (cyc >= free_cyc) begin
          x = longint'($signed(in_sample));
`ifdef MIC_COND_DC_EN
          y = x - (m_dc >>> 8);
          m_dc = m_dc + y;
`else
          y = x;
`endif
          m_sum = m_sum + y;
          m_n++;
          if (m_n == DECIM) begin
            due_cyc.push_back(cyc + 3);
            due_v0.push_back(model_out(m_sum, 0));
            due_v2.push_back(model_out(m_sum, 2));
            m_sum = 0; m_n = 0; free_cyc = cyc + 4;
          end else begin
            free_cyc = cyc + 3;
          end
        end else begin
          set = 1;
        end
      end
      if (set) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      cyc++;
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("valid", out_valid, q0.size() != 0);
      check("level", fifo_level, q0.size());
      check("ovf", overflow, m_ovf);
      check("valid_g2", out_valid_g2, q2.size() != 0);
      check("level_g2", fifo_level_g2, q2.size());
      check("ovf_g2", overflow_g2, m_ovf);
      if (q0.size() != 0) begin
        check("data", out_data, q0[0]);
        check("data_g2", out_data_g2, q2[0]);
      end
    end
  end

  // Capture of words accepted by the consumer (used by the DC decay test).
  logic [15:0] seen[$];
  bit          cap_en = 0;
  always @(posedge clk) begin
    if (cap_en && out_valid && out_ready) seen.push_back(out_data);
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic [23:0] v, input int gap);
    @(negedge clk); in_sample = v; in_rdy = 1'b1;
    @(negedge clk); in_rdy = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
  endtask

  logic [23:0] pat [8] = '{24'h123456, 24'hFEDCBA, 24'h7FFFFF, 24'h800000,
                           24'h000001, 24'hFFFFFF, 24'h3A5C00, 24'hC00000};

  initial begin
    rst = 1'b0; enable = 1'b0; in_sample = '0; in_rdy = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk); #2 rst = 1'b1; enable = 1'b1;

    // 1: four equal samples, latency of the first output, hold while stalled.
    for (int i = 0; i < 3; i++) strobe(24'h100000, 8);
    @(negedge clk); in_sample = 24'h100000; in_rdy = 1'b1;
    @(negedge clk); in_rdy = 1'b0;
    idle(2);
    check("lat_not_yet", out_valid, 0);
    idle(1);
    check("lat_valid", out_valid, 1);
`ifndef MIC_COND_DC_EN
    check("lit_dc_off", out_data, 16'h1000);
`else
    check("lit_dc_first", (out_data >= 16'h0F00) && (out_data < 16'h1000), 1);
`endif
    idle(6);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("pop_empty", out_valid, 0);

    // 2: mixed-sign pattern including full-scale extremes, consumer ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) strobe(pat[i], 6);
    idle(8);

    // 3: saturation with gain 2 on the second instance.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(24'h200000, 5);
    for (int i = 0; i < 4; i++) strobe(24'hE00000, 5);
    idle(6);
`ifndef MIC_COND_DC_EN
    check("lit_pos_g0", out_data, 16'h2000);
    check("lit_pos_g2", out_data_g2, 16'h7FFF);
`endif
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
`ifndef MIC_COND_DC_EN
    check("lit_neg_g0", out_data, 16'hE000);
    check("lit_neg_g2", out_data_g2, 16'h8000);
`endif
    @(negedge clk); out_ready = 1'b1;
    idle(3);

    // 4: 17 outputs with consumer stalled -> full, overflow, stable head.
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++)
      for (int j = 0; j < 4; j++) strobe(24'h050000 + 24'(k * 32'h031000), 5);
    idle(6);
    check("full_level", fifo_level, 16);
    check("full_ovf", overflow, 1);
`ifndef MIC_COND_DC_EN
    check("full_head", out_data, 16'h0500);
`endif
    pulse_clr();
    check("ovf_cleared", overflow, 0);
    out_ready = 1'b1;
    idle(20);

    // 5: second strobe 2 clk after the first is dropped, sum keeps only the first.
    out_ready = 1'b0;
    @(negedge clk); in_sample = 24'h100000; in_rdy = 1'b1;
    @(negedge clk); in_rdy = 1'b0;
    @(negedge clk); in_sample = 24'h7FFFFF; in_rdy = 1'b1;
    @(negedge clk); in_rdy = 1'b0;
    check("drop_ovf", overflow, 1);
    idle(4);
    for (int i = 0; i < 3; i++) strobe(24'h100000, 5);
    idle(5);
`ifndef MIC_COND_DC_EN
    check("drop_sum", out_data, 16'h1000);
`endif
    pulse_clr();
    out_ready = 1'b1;
    idle(3);

    // 6: enable=0 between samples discards the partial block.
    strobe(24'h7FFFFF, 5);
    strobe(24'h7FFFFF, 5);
    @(negedge clk); enable = 1'b0;
    strobe(24'h7FFFFF, 5);
    @(negedge clk); enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(24'h100000, 5);
    idle(5);
`ifndef MIC_COND_DC_EN
    check("en_partial", out_data, 16'h1000);
`endif
    @(negedge clk); out_ready = 1'b1;
    idle(3);

    // 7: async reset in S_ACC with five words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) strobe(24'h020000 + 24'(i * 32'h001000), 5);
    idle(5);
    check("pre_rst_level", fifo_level, 5);
    @(negedge clk); in_sample = 24'h100000; in_rdy = 1'b1;
    @(negedge clk); in_rdy = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_data", out_data, 0);
    check("arst_ovf", overflow, 0);
    check("arst_level_g2", fifo_level_g2, 0);
    @(negedge clk); #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) strobe(24'h100000, 5);
    idle(4);
    check("rst_three", out_valid, 0);
    strobe(24'h100000, 5);
    idle(2);
    check("rst_four", out_valid, 1);
`ifndef MIC_COND_DC_EN
    check("rst_four_data", out_data, 16'h1000);
`endif
    out_ready = 1'b1;
    idle(3);

`ifdef MIC_COND_DC_EN
    // 8: long constant input decays toward zero through the DC tracker.
    begin
      int bad;
      bad = 0;
      seen.delete();
      cap_en = 1;
      for (int i = 0; i < 4096; i++) strobe(24'h100000, 5);
      idle(6);
      cap_en = 0;
      check("dc_count", seen.size(), 1024);
      for (int i = 1; i < seen.size(); i++)
        if ($signed(seen[i]) > $signed(seen[i-1])) bad++;
      check("dc_monotonic", bad, 0);
      if (seen.size() != 0)
        check("dc_final_small", $signed(seen[seen.size()-1]) <= 2 &&
                                $signed(seen[seen.size()-1]) >= -2, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_sample_cond.md
Name: mic_sample_cond

Overview:
Conditions the raw 24-bit I2S microphone samples for the speech front-end. It sits directly downstream of the I2S microphone receiver and consumes that block's `out` bus and one-cycle `rdy` strobe. Per sample, it removes DC offset, then decimates by block averaging. The result is scaled and saturated to 16 bits and buffered in a small FIFO with a valid/ready interface for the feature-extraction stage.

Parameters:
- IN_W, 24, input sample width (two's complement, MSB-first from I2S).
- OUT_W, 16, output sample width.
- DECIM, 4, decimation factor; power of two, 1..16.
- DC_SHIFT, 8, DC-tracker time constant; the estimate moves by y/2^DC_SHIFT per sample.
- GAIN_SHIFT, 0, left shift applied after averaging, 0..7.
- FIFO_DEPTH, 16, output FIFO entries; power of two.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset. One clock; reset is asynchronous and active-low.
- enable, in, 1, conditioning enable.
- in_sample, in, IN_W, sample from the mic receiver.
- in_rdy, in, 1, one-cycle strobe; `in_sample` is valid only in that cycle.
- out_data, out, OUT_W, conditioned sample (FIFO head).
- out_valid, out, 1, FIFO non-empty.
- out_ready, in, 1, consumer accepts the head.
- fifo_level, out, clog2(FIFO_DEPTH)+1, FIFO occupancy.
- overflow, out, 1, sticky error flag.
- clr_ovf, in, 1, clears `overflow`.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=S_IDLE, DC estimate 0, accumulator 0, decimation count 0, FIFO empty.
- FSM states and transitions:
  - S_IDLE: waits for in_rdy while enable=1. On the strobe, latches in_sample as signed x, then goes to S_DC.
  - S_DC: computes y = x - (dc_acc >>> DC_SHIFT) and updates dc_acc += y. dc_acc is IN_W+DC_SHIFT bits signed. Goes to S_ACC.
  - S_ACC: sum += y (sum is IN_W+clog2(DECIM)+1 bits signed) and cnt++. If cnt reached DECIM, goes to S_PUSH; otherwise returns to S_IDLE.
  - S_PUSH: computes avg = sum >>> clog2(DECIM), then v = (avg <<< GAIN_SHIFT) >>> (IN_W-OUT_W). v is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and written to the FIFO. Clears sum and cnt, then returns to S_IDLE.
- Latency: in_rdy of the DECIM-th sample at cycle N gives the FIFO write at N+3 and out_valid=1 at N+4 if the FIFO was empty.
- Busy drop: an in_rdy arriving while FSM≠S_IDLE is discarded and sets `overflow`. Upstream spacing is ≥128 clk, so this is an error case only.
- FIFO:
  - First-word-fall-through.
  - Pop occurs when out_valid & out_ready.
  - out_data holds stable while out_valid & !out_ready.
  - A write when full is dropped and sets `overflow`.
  - A simultaneous push and pop when full is allowed: both occur and there is no overflow.
  - Push and pop in the same cycle leave fifo_level unchanged.
- overflow: set has priority over a same-cycle clr_ovf.
- enable=0:
  - FSM forced to S_IDLE; an in-flight sample is abandoned.
  - sum and cnt are cleared.
  - The DC estimate and FIFO contents are retained, and the FIFO still drains.
- Arithmetic: `>>>` is arithmetic shift. Saturation is applied once, in S_PUSH.

Optional Feature:
- Macro: MIC_COND_DC_EN.
- Defined: the DC-removal stage operates as above.
- Undefined: S_DC passes y = x and no dc_acc register exists. State sequence and latency are identical.

Decomposition:
- Package mic_pkg:
  - state enum (S_IDLE, S_DC, S_ACC, S_PUSH);
  - MIC_IN_W and MIC_OUT_W constants;
  - a saturate(value, width) function.
- Sub-module: sample_fifo. Parameterised width/depth, FWFT, with push/pop/full/empty/level and drop-on-full.

Test Plan (DECIM=4, DC_SHIFT=8, GAIN_SHIFT=0, FIFO_DEPTH=16):
- DC off: 4 strobes of in_sample=0x100000 at 128-clk spacing → one output 0x1000; out_valid rises 4 clk after the 4th strobe.
- DC on: constant 0x100000 for 4096 strobes → outputs decay monotonically from 0x0FF? toward 0; the final output magnitude is ≤0x0002.
- GAIN_SHIFT=2, DC off, samples 0x200000 → output saturates to 0x7FFF; samples 0xE00000 → 0x8000.
- out_ready=0 for 17 decimated outputs → fifo_level=16 and overflow=1. clr_ovf then clears it. out_data shows the first value, unchanged throughout.
- Two in_rdy 2 clk apart → second sample dropped, overflow=1, and the sum includes only the first.
- Async reset asserted mid-S_ACC with FIFO level 5 → all outputs 0 immediately. After release, the first output needs 4 new samples.
